hdmi_timing_gen: RTL and testbench
==================================

# hdmi_timing_gen

- Parametrised HDMI/DVI raster timing generator that replaces the fixed 640x480@60 generator.
- Drives the TMDS encoders' period selection, sync and CTL lines, and supplies pixel coordinates to content logic.
- New relative to the fixed generator: programmable geometry and sync polarity, explicit period code, border flag, frame and line strobes.
- Also schedules an optional per-line data island (preamble, guard bands, N packets) under a request/acknowledge handshake with the packet source.

## Interface
- H_SYNC, H_BP, H_LB, H_ADDR, H_RB, H_FP: 96, 40, 8, 640, 8, 8. Horizontal segment lengths in pixels.
- V_SYNC, V_BP, V_TB, V_ADDR, V_BB, V_FP: 2, 25, 8, 480, 8, 2. Vertical segment lengths in lines.
- H_POL, V_POL: 0, 0. Sync asserted level.
- DI_PACKETS: 1. Packets per island, range 0..18; 0 disables islands.
- DI_H_START: 8. Horizontal position of the first island preamble cycle.
- pixel_clk  in  1  pixel clock. Single clock domain.
- n_rst  in  1  asynchronous, active-low reset.
- di_req  in  1  packet source requests an island on the next line.
- h_sync, v_sync  out  1  sync, level per H_POL/V_POL.
- ctl_0..ctl_3  out  1  TMDS CTL bits.
- period  out  3  period code, see Structure.
- de  out  1  video data period: borders plus addressable area.
- active_video  out  1  addressable area only.
- border  out  1  de and not active_video.
- video_gb, data_island_gb  out  1  guard band flags.
- sx  out  $clog2(H_ADDR)  addressable x.
- sy  out  $clog2(V_ADDR)  addressable y.
- line_start, frame_start  out  1  single-cycle strobes.
- di_ack  out  1  single-cycle island grant.
- di_pkt  out  5  packet index during island data.
- di_word  out  5  word index 0..31 during island data.

## Operation
- Derived totals: H_TOTAL = sum of the H segments, V_TOTAL = sum of the V segments.
- Internal h/v counters wrap at H_TOTAL-1 and V_TOTAL-1; v advances only when h wraps.
- Position (h,v) below means the position the outputs currently show.
- All outputs are registered.
- Segment order per axis: SYNC, BP, LB/TB, ADDR, RB/BB, FP, starting at position 0.
- Sync is at its asserted level when h<H_SYNC (v<V_SYNC for v_sync); otherwise at its inverse.
- de: h in [HS, HS+H_LB+H_ADDR+H_RB) and v in [V_SYNC+V_BP, V_TOTAL-V_FP), where HS = H_SYNC+H_BP.
- active_video: h in [HS+H_LB, HS+H_LB+H_ADDR) and v within the addressable line range.
- sx and sy are the offsets into the addressable area; both read 0 whenever active_video=0.
- Video preamble on de lines only:
  - Positions HS-10..HS-3: period VID_PRE, CTL = 1,0,0,0.
  - Positions HS-2..HS-1: period VID_GB, video_gb=1.
- Island handshake:
  - di_req is sampled in the cycle where line_start=1.
  - If di_req=1 and DI_PACKETS>0, an island is scheduled on that line and di_ack pulses at h=1.
  - If di_req is held high, an island runs on every line.
- Island sequence, with S = DI_H_START:
  - DI_PRE at S..S+7, CTL = 1,0,1,0.
  - DI_GB_LEAD at S+8..S+9.
  - DI_DATA for 32*DI_PACKETS cycles. di_word counts 0..31; di_pkt increments after each word-31 cycle.
  - DI_GB_TRAIL for 2 cycles.
  - data_island_gb=1 during both guard bands.
- All other positions: period CTRL, CTL all 0, di_pkt and di_word 0.
- Elaboration fatal checks:
  - S >= 4.
  - S+12+32*DI_PACKETS <= HS-12.
  - DI_PACKETS <= 18.
- Reset asserted: counters and registered outputs clear immediately.
- Reset values:
  - h_sync = ~H_POL, v_sync = ~V_POL; all other outputs 0.
  - Any pending or running island is discarded.

## Timing
- First clock after n_rst deasserts: outputs show (0,0) with line_start=1 and frame_start=1.
- line_start: 1 at h=0 on every line.
- frame_start: 1 at (0,0) only.
- Output latency is 1 cycle from the internal counter. Downstream sees a consistent position on all outputs within the same cycle.
- Wrap: (H_TOTAL-1, V_TOTAL-1) is followed by (0,0).
- di_req changes outside line_start cycles have no effect.
- An island never straddles a line.

## Structure
- Shared package hdmi_timing_pkg holds:
  - The period enum: CTRL=0, VID_PRE, VID_GB, VIDEO, DI_PRE, DI_GB_LEAD, DI_DATA, DI_GB_TRAIL.
  - Preamble CTL constants.
  - Preamble length 8, guard band length 2, packet length 32.
- One sub-module, timing_axis, instantiated for h and v: counter, wrap and segment decode, parametrised by segment lengths.
- Island scheduling and period muxing stay in the top level.

## Test plan
- Reset release with defaults:
  - First cycle shows h=0, v=0, frame_start=1, h_sync=0.
  - h_sync returns to 1 at h=96.
  - Line length is 800 cycles; frame length is 420000 cycles.
- Line v=35:
  - VID_PRE at h=126..133 with ctl_0=1; VID_GB at h=134..135.
  - de rises at h=136 with border=1.
  - active_video rises at h=144 with sx=0; sx=639 at h=783.
  - de falls at h=792.
- Vertical extents: de=0 on v=26 and v=523; active_video=0 on v=34, 1 on v=35 (sy=0), 1 on v=514 (sy=479).
- di_req=1 held for a single line_start, then dropped:
  - di_ack at h=1.
  - DI_PRE at h=8..15 with ctl_2=1, guard band at h=16..17.
  - DI_DATA at h=18..49 with di_word 0..31, trailing guard band at h=50..51.
  - Next line: CTRL throughout the blanking interval, no island.
- Parameters DI_PACKETS=3, H_POL=1, di_req held high:
  - Island data on every line, di_pkt stepping 0→1→2 at h=50 and h=82.
  - h_sync is high during h<96.
- n_rst pulsed at h=30 during an island: outputs clear immediately; after release, outputs show (0,0) and no stale island appears.

Source files
------------

// File: rtl/hdmi_timing_pkg.sv
// Shared definitions for the HDMI/DVI raster timing generator: period codes,
// preamble CTL patterns and island segment lengths.
package hdmi_timing_pkg;

    typedef enum logic [2:0] {
        CTRL        = 3'd0,
        VID_PRE     = 3'd1,
        VID_GB      = 3'd2,
        VIDEO       = 3'd3,
        DI_PRE      = 3'd4,
        DI_GB_LEAD  = 3'd5,
        DI_DATA     = 3'd6,
        DI_GB_TRAIL = 3'd7
    } period_t;

    localparam int PRE_LEN = 8;
    localparam int GB_LEN  = 2;
    localparam int PKT_LEN = 32;

    // Bit n of each pattern drives ctl_n.
    localparam logic [3:0] CTL_IDLE    = 4'b0000;
    localparam logic [3:0] CTL_VID_PRE = 4'b0001;
    localparam logic [3:0] CTL_DI_PRE  = 4'b0101;

    function automatic int off_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hdmi_timing_gen_if.sv
// Timing outputs and packet-source handshake of the raster generator.
interface hdmi_timing_gen_if #(
    parameter int H_ADDR = 640,
    parameter int V_ADDR = 480
) ();
    import hdmi_timing_pkg::*;

    localparam int SXW = off_width(H_ADDR);
    localparam int SYW = off_width(V_ADDR);

    logic           di_req;
    logic           h_sync;
    logic           v_sync;
    logic           ctl_0;
    logic           ctl_1;
    logic           ctl_2;
    logic           ctl_3;
    period_t        period;
    logic           de;
    logic           active_video;
    logic           border;
    logic           video_gb;
    logic           data_island_gb;
    logic [SXW-1:0] sx;
    logic [SYW-1:0] sy;
    logic           line_start;
    logic           frame_start;
    logic           di_ack;
    logic [4:0]     di_pkt;
    logic [4:0]     di_word;

    modport master (
        input  di_req,
        output h_sync, v_sync, ctl_0, ctl_1, ctl_2, ctl_3, period, de,
               active_video, border, video_gb, data_island_gb, sx, sy,
               line_start, frame_start, di_ack, di_pkt, di_word
    );

    modport slave (
        output di_req,
        input  h_sync, v_sync, ctl_0, ctl_1, ctl_2, ctl_3, period, de,
               active_video, border, video_gb, data_island_gb, sx, sy,
               line_start, frame_start, di_ack, di_pkt, di_word
    );

endinterface

// File: rtl/timing_axis.sv
// One raster axis: wrapping position counter plus sync / data-enable /
// addressable-area decode of the current count.
module timing_axis
    import hdmi_timing_pkg::*;
#(
    parameter int SYNC = 96,
    parameter int BP   = 40,
    parameter int LB   = 8,
    parameter int ADDR = 640,
    parameter int RB   = 8,
    parameter int FP   = 8,
    parameter int CW   = $clog2(SYNC + BP + LB + ADDR + RB + FP),
    parameter int OW   = off_width(ADDR)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          adv,
    output logic [CW-1:0] cnt,
    output logic          in_sync,
    output logic          in_de,
    output logic          in_addr,
    output logic [OW-1:0] off
);

    localparam int TOTAL = SYNC + BP + LB + ADDR + RB + FP;

    localparam logic [CW-1:0] LAST   = CW'(TOTAL - 1);
    localparam logic [CW-1:0] SY_END = CW'(SYNC);
    localparam logic [CW-1:0] DE_BEG = CW'(SYNC + BP);
    localparam logic [CW-1:0] AD_BEG = CW'(SYNC + BP + LB);
    localparam logic [CW-1:0] AD_END = CW'(SYNC + BP + LB + ADDR);
    localparam logic [CW-1:0] DE_END = CW'(SYNC + BP + LB + ADDR + RB);

    logic [CW-1:0] rel;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (adv) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign rel     = cnt - AD_BEG;
    assign in_sync = (cnt < SY_END);
    assign in_de   = (cnt >= DE_BEG) && (cnt < DE_END);
    assign in_addr = (cnt >= AD_BEG) && (cnt < AD_END);
    assign off     = in_addr ? rel[OW-1:0] : '0;

endmodule

// File: rtl/hdmi_timing_gen.sv
// Parametrised HDMI/DVI raster timing generator with video preambles and an
// optional per-line data island granted by a request/acknowledge handshake.
module hdmi_timing_gen
    import hdmi_timing_pkg::*;
#(
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 40,
    parameter int   H_LB       = 8,
    parameter int   H_ADDR     = 640,
    parameter int   H_RB       = 8,
    parameter int   H_FP       = 8,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 25,
    parameter int   V_TB       = 8,
    parameter int   V_ADDR     = 480,
    parameter int   V_BB       = 8,
    parameter int   V_FP       = 2,
    parameter logic H_POL      = 1'b0,
    parameter logic V_POL      = 1'b0,
    parameter int   DI_PACKETS = 1,
    parameter int   DI_H_START = 8
) (
    input  logic                pixel_clk,
    input  logic                n_rst,
    hdmi_timing_gen_if.master   bus
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_LB + H_ADDR + H_RB + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_TB + V_ADDR + V_BB + V_FP;
    localparam int HS      = H_SYNC + H_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int SXW     = off_width(H_ADDR);
    localparam int SYW     = off_width(V_ADDR);
    localparam int DI_END  = DI_H_START + PRE_LEN + 2 * GB_LEN + PKT_LEN * DI_PACKETS;

    localparam logic ISLANDS_ON = (DI_PACKETS > 0);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] VP_BEG = HW'(HS - 10);
    localparam logic [HW-1:0] VG_BEG = HW'(HS - 2);
    localparam logic [HW-1:0] VG_END = HW'(HS);
    localparam logic [HW-1:0] DP_BEG = HW'(DI_H_START);
    localparam logic [HW-1:0] DL_BEG = HW'(DI_H_START + PRE_LEN);
    localparam logic [HW-1:0] DD_BEG = HW'(DI_H_START + PRE_LEN + GB_LEN);
    localparam logic [HW-1:0] DT_BEG = HW'(DI_H_START + PRE_LEN + GB_LEN + PKT_LEN * DI_PACKETS);
    localparam logic [HW-1:0] DT_END = HW'(DI_END);

    if (DI_H_START < 4) begin : g_chk_start
        $fatal(1, "hdmi_timing_gen: DI_H_START must be at least 4");
    end
    if (DI_END > HS - 12) begin : g_chk_fit
        $fatal(1, "hdmi_timing_gen: data island does not fit before the video preamble");
    end
    if (DI_PACKETS > 18) begin : g_chk_pkts
        $fatal(1, "hdmi_timing_gen: DI_PACKETS must not exceed 18");
    end

    logic [HW-1:0]  h_cnt;
    logic [VW-1:0]  v_cnt;
    logic           h_in_sync, h_in_de, h_in_addr;
    logic           v_in_sync, v_in_de, v_in_addr;
    logic [SXW-1:0] h_off;
    logic [SYW-1:0] v_off;
    logic           h_last;
    logic           island_line;

    timing_axis #(
        .SYNC(H_SYNC), .BP(H_BP), .LB(H_LB), .ADDR(H_ADDR), .RB(H_RB), .FP(H_FP)
    ) u_h_axis (
        .clk(pixel_clk), .n_rst(n_rst), .adv(1'b1), .cnt(h_cnt),
        .in_sync(h_in_sync), .in_de(h_in_de), .in_addr(h_in_addr), .off(h_off)
    );

    timing_axis #(
        .SYNC(V_SYNC), .BP(V_BP), .LB(V_TB), .ADDR(V_ADDR), .RB(V_BB), .FP(V_FP)
    ) u_v_axis (
        .clk(pixel_clk), .n_rst(n_rst), .adv(h_last), .cnt(v_cnt),
        .in_sync(v_in_sync), .in_de(v_in_de), .in_addr(v_in_addr), .off(v_off)
    );

    assign h_last = (h_cnt == H_LAST);

    logic        de_n, av_n;
    period_t     period_n;
    logic [3:0]  ctl_n;
    logic        vgb_n, dgb_n;
    logic [4:0]  pkt_n, word_n;
    logic [9:0]  data_off;

    assign de_n     = h_in_de && v_in_de;
    assign av_n     = h_in_addr && v_in_addr;
    assign data_off = 10'(h_cnt - DD_BEG);

    // Video preamble and guard band only lead into lines that carry data.
    always_comb begin
        period_n = CTRL;
        ctl_n    = CTL_IDLE;
        vgb_n    = 1'b0;
        dgb_n    = 1'b0;
        pkt_n    = '0;
        word_n   = '0;
        if (de_n) begin
            period_n = VIDEO;
        end else if (v_in_de && h_cnt >= VP_BEG && h_cnt < VG_BEG) begin
            period_n = VID_PRE;
            ctl_n    = CTL_VID_PRE;
        end else if (v_in_de && h_cnt >= VG_BEG && h_cnt < VG_END) begin
            period_n = VID_GB;
            vgb_n    = 1'b1;
        end else if (island_line) begin
            if (h_cnt >= DP_BEG && h_cnt < DL_BEG) begin
                period_n = DI_PRE;
                ctl_n    = CTL_DI_PRE;
            end else if (h_cnt >= DL_BEG && h_cnt < DD_BEG) begin
                period_n = DI_GB_LEAD;
                dgb_n    = 1'b1;
            end else if (h_cnt >= DD_BEG && h_cnt < DT_BEG) begin
                period_n = DI_DATA;
                word_n   = data_off[4:0];
                pkt_n    = data_off[9:5];
            end else if (h_cnt >= DT_BEG && h_cnt < DT_END) begin
                period_n = DI_GB_TRAIL;
                dgb_n    = 1'b1;
            end
        end
    end

    // island_line holds the previous line's grant while h is 0..1; the island
    // never starts that early, so the stale value is harmless.
    always_ff @(posedge pixel_clk or negedge n_rst) begin
        if (!n_rst) begin
            bus.h_sync         <= ~H_POL;
            bus.v_sync         <= ~V_POL;
            bus.ctl_0          <= 1'b0;
            bus.ctl_1          <= 1'b0;
            bus.ctl_2          <= 1'b0;
            bus.ctl_3          <= 1'b0;
            bus.period         <= CTRL;
            bus.de             <= 1'b0;
            bus.active_video   <= 1'b0;
            bus.border         <= 1'b0;
            bus.video_gb       <= 1'b0;
            bus.data_island_gb <= 1'b0;
            bus.sx             <= '0;
            bus.sy             <= '0;
            bus.line_start     <= 1'b0;
            bus.frame_start    <= 1'b0;
            bus.di_ack         <= 1'b0;
            bus.di_pkt         <= '0;
            bus.di_word        <= '0;
            island_line        <= 1'b0;
        end else begin
            bus.h_sync         <= h_in_sync ? H_POL : ~H_POL;
            bus.v_sync         <= v_in_sync ? V_POL : ~V_POL;
            bus.ctl_0          <= ctl_n[0];
            bus.ctl_1          <= ctl_n[1];
            bus.ctl_2          <= ctl_n[2];
            bus.ctl_3          <= ctl_n[3];
            bus.period         <= period_n;
            bus.de             <= de_n;
            bus.active_video   <= av_n;
            bus.border         <= de_n && !av_n;
            bus.video_gb       <= vgb_n;
            bus.data_island_gb <= dgb_n;
            bus.sx             <= av_n ? h_off : '0;
            bus.sy             <= av_n ? v_off : '0;
            bus.line_start     <= (h_cnt == '0);
            bus.frame_start    <= (h_cnt == '0) && (v_cnt == '0);
            bus.di_ack         <= bus.line_start && bus.di_req && ISLANDS_ON;
            bus.di_pkt         <= pkt_n;
            bus.di_word        <= word_n;
            if (bus.line_start) begin
                island_line <= bus.di_req && ISLANDS_ON;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Directed bench: a default-geometry generator and a short-frame, three-packet,
// positive-hsync generator run side by side on one pixel clock.
module tb_hdmi_timing_gen;
    import hdmi_timing_pkg::*;

    logic clk     = 1'b0;
    logic n_rst_a = 1'b0;
    logic n_rst_b = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pos      = 0;

    always #5 clk = ~clk;

    hdmi_timing_gen_if #(.H_ADDR(640), .V_ADDR(480)) bus_a ();
    hdmi_timing_gen_if #(.H_ADDR(640), .V_ADDR(4))   bus_b ();

    hdmi_timing_gen dut_a (.pixel_clk(clk), .n_rst(n_rst_a), .bus(bus_a));

    hdmi_timing_gen #(
        .V_SYNC(2), .V_BP(3), .V_TB(1), .V_ADDR(4), .V_BB(1), .V_FP(2),
        .DI_PACKETS(3), .H_POL(1'b1)
    ) dut_b (.pixel_clk(clk), .n_rst(n_rst_b), .bus(bus_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to linear position target (cycles since (0,0)), sampled mid-cycle.
    task automatic at(input int target);
        if (target > pos) begin
            repeat (target - pos) @(posedge clk);
            @(negedge clk);
            pos = target;
        end
    endtask

    initial begin
        bus_a.di_req = 1'b0;
        bus_b.di_req = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_a_hsync",  32'(bus_a.h_sync), 1);
        check("rst_a_vsync",  32'(bus_a.v_sync), 1);
        check("rst_a_ls",     32'(bus_a.line_start), 0);
        check("rst_a_period", 32'(bus_a.period), 32'(CTRL));
        check("rst_b_hsync",  32'(bus_b.h_sync), 0);
        check("rst_b_ack",    32'(bus_b.di_ack), 0);

        n_rst_a = 1'b1;
        n_rst_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pos = 0;
        check("a0_ls",    32'(bus_a.line_start), 1);
        check("a0_fs",    32'(bus_a.frame_start), 1);
        check("a0_hsync", 32'(bus_a.h_sync), 0);
        check("a0_vsync", 32'(bus_a.v_sync), 0);
        check("b0_fs",    32'(bus_b.frame_start), 1);
        check("b0_hsync", 32'(bus_b.h_sync), 1);

        at(1);
        check("a1_ack",  32'(bus_a.di_ack), 0);
        check("b1_ack",  32'(bus_b.di_ack), 1);
        check("a1_ls",   32'(bus_a.line_start), 0);
        at(2);
        check("b2_ack",  32'(bus_b.di_ack), 0);
        at(49);
        check("b49_per", 32'(bus_b.period), 32'(DI_DATA));
        check("b49_pkt", 32'(bus_b.di_pkt), 0);
        check("b49_wd",  32'(bus_b.di_word), 31);
        at(50);
        check("b50_pkt", 32'(bus_b.di_pkt), 1);
        check("b50_wd",  32'(bus_b.di_word), 0);
        at(82);
        check("b82_pkt", 32'(bus_b.di_pkt), 2);
        at(95);
        check("a95_hsync", 32'(bus_a.h_sync), 0);
        check("b95_hsync", 32'(bus_b.h_sync), 1);
        at(96);
        check("a96_hsync", 32'(bus_a.h_sync), 1);
        check("b96_hsync", 32'(bus_b.h_sync), 0);
        at(113);
        check("b113_wd",  32'(bus_b.di_word), 31);
        check("b113_pkt", 32'(bus_b.di_pkt), 2);
        at(114);
        check("b114_per", 32'(bus_b.period), 32'(DI_GB_TRAIL));
        check("b114_gb",  32'(bus_b.data_island_gb), 1);
        at(116);
        check("b116_per", 32'(bus_b.period), 32'(CTRL));

        at(799);
        check("a799_ls", 32'(bus_a.line_start), 0);
        at(800);
        check("a800_ls", 32'(bus_a.line_start), 1);
        check("a800_fs", 32'(bus_a.frame_start), 0);
        at(801);
        check("b801_ack", 32'(bus_b.di_ack), 1);
        at(850);
        check("b850_pkt", 32'(bus_b.di_pkt), 1);
        at(1599);
        check("a1599_vsync", 32'(bus_a.v_sync), 0);
        at(1600);
        check("a1600_vsync", 32'(bus_a.v_sync), 1);

        at(3600);
        check("b_v4_de", 32'(bus_b.de), 0);
        at(4400);
        check("b_v5_de",  32'(bus_b.de), 1);
        check("b_v5_av",  32'(bus_b.active_video), 0);
        check("b_v5_bdr", 32'(bus_b.border), 1);
        at(4944);
        check("b_v6_av",  32'(bus_b.active_video), 1);
        check("b_v6_sx",  32'(bus_b.sx), 0);
        check("b_v6_sy",  32'(bus_b.sy), 0);
        at(7983);
        check("b_v9_av",  32'(bus_b.active_video), 1);
        check("b_v9_sx",  32'(bus_b.sx), 639);
        check("b_v9_sy",  32'(bus_b.sy), 3);
        at(8400);
        check("b_v10_av", 32'(bus_b.active_video), 0);
        check("b_v10_sy", 32'(bus_b.sy), 0);
        at(9200);
        check("b_v11_de", 32'(bus_b.de), 0);
        at(10399);
        check("b10399_fs", 32'(bus_b.frame_start), 0);
        at(10400);
        check("b10400_fs", 32'(bus_b.frame_start), 1);
        check("a10400_fs", 32'(bus_a.frame_start), 0);

        at(20926);
        check("a_v26_per", 32'(bus_a.period), 32'(CTRL));
        at(21200);
        check("a_v26_de",  32'(bus_a.de), 0);
        at(27600);
        check("a_v34_de",  32'(bus_a.de), 1);
        check("a_v34_av",  32'(bus_a.active_video), 0);

        at(28125);
        check("a35_125_per", 32'(bus_a.period), 32'(CTRL));
        at(28126);
        check("a35_126_per", 32'(bus_a.period), 32'(VID_PRE));
        check("a35_126_c0",  32'(bus_a.ctl_0), 1);
        check("a35_126_c2",  32'(bus_a.ctl_2), 0);
        at(28133);
        check("a35_133_per", 32'(bus_a.period), 32'(VID_PRE));
        at(28134);
        check("a35_134_per", 32'(bus_a.period), 32'(VID_GB));
        check("a35_134_vgb", 32'(bus_a.video_gb), 1);
        check("a35_134_c0",  32'(bus_a.ctl_0), 0);
        at(28135);
        check("a35_135_vgb", 32'(bus_a.video_gb), 1);
        at(28136);
        check("a35_136_de",  32'(bus_a.de), 1);
        check("a35_136_bdr", 32'(bus_a.border), 1);
        check("a35_136_per", 32'(bus_a.period), 32'(VIDEO));
        check("a35_136_vgb", 32'(bus_a.video_gb), 0);
        at(28143);
        check("a35_143_av",  32'(bus_a.active_video), 0);
        at(28144);
        check("a35_144_av",  32'(bus_a.active_video), 1);
        check("a35_144_sx",  32'(bus_a.sx), 0);
        check("a35_144_sy",  32'(bus_a.sy), 0);
        check("a35_144_bdr", 32'(bus_a.border), 0);
        at(28145);
        check("a35_145_sx",  32'(bus_a.sx), 1);
        at(28783);
        check("a35_783_sx",  32'(bus_a.sx), 639);
        at(28784);
        check("a35_784_av",  32'(bus_a.active_video), 0);
        check("a35_784_sx",  32'(bus_a.sx), 0);
        check("a35_784_bdr", 32'(bus_a.border), 1);
        at(28791);
        check("a35_791_de",  32'(bus_a.de), 1);
        at(28792);
        check("a35_792_de",  32'(bus_a.de), 0);
        check("a35_792_per", 32'(bus_a.period), 32'(CTRL));

        // Single-line island request on line 36.
        at(28799);
        bus_a.di_req = 1'b1;
        at(28800);
        check("a36_0_ls",  32'(bus_a.line_start), 1);
        at(28801);
        bus_a.di_req = 1'b0;
        check("a36_1_ack", 32'(bus_a.di_ack), 1);
        at(28802);
        check("a36_2_ack", 32'(bus_a.di_ack), 0);
        at(28807);
        check("a36_7_per", 32'(bus_a.period), 32'(CTRL));
        at(28808);
        check("a36_8_per", 32'(bus_a.period), 32'(DI_PRE));
        check("a36_8_c0",  32'(bus_a.ctl_0), 1);
        check("a36_8_c2",  32'(bus_a.ctl_2), 1);
        check("a36_8_c1",  32'(bus_a.ctl_1), 0);
        at(28815);
        check("a36_15_per", 32'(bus_a.period), 32'(DI_PRE));
        at(28816);
        check("a36_16_per", 32'(bus_a.period), 32'(DI_GB_LEAD));
        check("a36_16_gb",  32'(bus_a.data_island_gb), 1);
        at(28817);
        check("a36_17_gb",  32'(bus_a.data_island_gb), 1);
        at(28818);
        check("a36_18_per", 32'(bus_a.period), 32'(DI_DATA));
        check("a36_18_wd",  32'(bus_a.di_word), 0);
        check("a36_18_gb",  32'(bus_a.data_island_gb), 0);
        at(28833);
        check("a36_33_wd",  32'(bus_a.di_word), 15);
        at(28849);
        check("a36_49_wd",  32'(bus_a.di_word), 31);
        check("a36_49_pkt", 32'(bus_a.di_pkt), 0);
        at(28850);
        check("a36_50_per", 32'(bus_a.period), 32'(DI_GB_TRAIL));
        check("a36_50_wd",  32'(bus_a.di_word), 0);
        at(28851);
        check("a36_51_gb",  32'(bus_a.data_island_gb), 1);
        at(28852);
        check("a36_52_per", 32'(bus_a.period), 32'(CTRL));
        check("a36_52_gb",  32'(bus_a.data_island_gb), 0);

        at(29601);
        check("a37_1_ack",  32'(bus_a.di_ack), 0);
        at(29605);
        bus_a.di_req = 1'b1;
        at(29606);
        bus_a.di_req = 1'b0;
        at(29618);
        check("a37_18_per", 32'(bus_a.period), 32'(CTRL));
        at(30401);
        check("a38_1_ack",  32'(bus_a.di_ack), 0);
        at(30418);
        check("a38_18_per", 32'(bus_a.period), 32'(CTRL));

        // Reset pulse in the middle of a running island on line 39.
        at(31199);
        bus_a.di_req = 1'b1;
        at(31201);
        bus_a.di_req = 1'b0;
        check("a39_1_ack", 32'(bus_a.di_ack), 1);
        at(31230);
        check("a39_30_per", 32'(bus_a.period), 32'(DI_DATA));
        check("a39_30_wd",  32'(bus_a.di_word), 12);
        n_rst_a = 1'b0;
        #1;
        check("arst_per",   32'(bus_a.period), 32'(CTRL));
        check("arst_wd",    32'(bus_a.di_word), 0);
        check("arst_hsync", 32'(bus_a.h_sync), 1);
        check("arst_ls",    32'(bus_a.line_start), 0);
        @(negedge clk);
        n_rst_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pos = 0;
        check("arel_ls",    32'(bus_a.line_start), 1);
        check("arel_fs",    32'(bus_a.frame_start), 1);
        check("arel_hsync", 32'(bus_a.h_sync), 0);
        at(1);
        check("arel_ack",   32'(bus_a.di_ack), 0);
        at(8);
        check("arel_8_per", 32'(bus_a.period), 32'(CTRL));
        at(30);
        check("arel_30_per", 32'(bus_a.period), 32'(CTRL));
        check("arel_30_wd",  32'(bus_a.di_word), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
